adder2_seq_ctrl: RTL and testbench

//  Sequencer that performs a WIDTH-bit add by reusing one 2-bit ripple-adder slice
//  for WIDTH/2 cycles. The result is built in a shift register, LSB pair first.

---
 rtl/adder2_seq_ctrl_pkg.sv | 19 +
 rtl/adder2_seq_ctrl_if.sv | 29 ++
 rtl/adder2_seq_ctrl_slice.sv | 20 ++
 rtl/adder2_seq_ctrl.sv | 118 +++++++++++
 tb/tb_adder2_seq_ctrl.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/adder2_seq_ctrl_pkg.sv
// Shared definitions for the serial 2-bit-slice adder sequencer.
package adder2_seq_ctrl_pkg;

    // Default operand/result width
    localparam int DEFAULT_WIDTH = 8;

    // Sequencer states; the unused code 2'd3 falls back to IDLE
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Width of the step counter: one spare bit so it cannot wrap mid-operation
    function automatic int step_width(input int nstep);
        return $clog2(nstep) + 1;
    endfunction

endpackage

// File: rtl/adder2_seq_ctrl_if.sv
// Operand and result handshake bundle for the serial adder.
import adder2_seq_ctrl_pkg::*;

interface adder2_seq_ctrl_if #(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    // Operand source / result consumer side
    modport master (
        output start_valid, a, b, cin, res_ready,
        input  start_ready, busy, res_valid, sum, cout
    );

    // Adder sequencer side
    modport slave (
        input  start_valid, a, b, cin, res_ready,
        output start_ready, busy, res_valid, sum, cout
    );
endinterface

// File: rtl/adder2_seq_ctrl_slice.sv
// Combinational 2-bit ripple adder; the only arithmetic in the sequencer.
module adder2_slice (
    input  logic [1:0] x,
    input  logic [1:0] y,
    input  logic       ci,
    output logic [1:0] s,
    output logic       co
);
    logic [2:0] c;

    assign c[0] = ci;

    // One full-adder cell per bit, carry rippling upward
    for (genvar gi = 0; gi < 2; gi++) begin : g_bit
        assign s[gi]   = x[gi] ^ y[gi] ^ c[gi];
        assign c[gi+1] = (x[gi] & y[gi]) | (c[gi] & (x[gi] ^ y[gi]));
    end

    assign co = c[2];
endmodule

// File: rtl/adder2_seq_ctrl.sv
// Sequencer that computes a WIDTH-bit add by iterating one 2-bit slice,
// least-significant pair first, behind valid/ready handshakes.
import adder2_seq_ctrl_pkg::*;

module adder2_seq_ctrl #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    adder2_seq_ctrl_if.slave  bus
);
    localparam int NSTEP = WIDTH / 2;
    localparam int STEPW = step_width(NSTEP);

    state_t             state_reg;
    state_t             state_next;
    logic [STEPW-1:0]   step_reg;
    logic               carry_reg;
    logic [WIDTH-1:0]   a_sh_reg;
    logic [WIDTH-1:0]   b_sh_reg;
    logic [WIDTH-1:0]   sum_sh_reg;
    logic [WIDTH-1:0]   sum_out_reg;
    logic               cout_out_reg;

    logic [1:0]         slice_s;
    logic               slice_co;
    logic [WIDTH-1:0]   sum_sh_next;
    logic               last_step;

    adder2_slice u_slice (
        .x  (a_sh_reg[1:0]),
        .y  (b_sh_reg[1:0]),
        .ci (carry_reg),
        .s  (slice_s),
        .co (slice_co)
    );

    // New slice result enters at the top; earlier pairs move toward bit 0
    assign sum_sh_next = (sum_sh_reg >> 2) | (WIDTH'(slice_s) << (WIDTH - 2));
    assign last_step   = (step_reg == STEPW'(NSTEP - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_next      = ST_IDLE;
        bus.start_ready = 1'b0;
        bus.busy        = 1'b0;
        bus.res_valid   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                bus.start_ready = 1'b1;
                state_next      = bus.start_valid ? ST_RUN : ST_IDLE;
            end
            ST_RUN: begin
                bus.busy   = 1'b1;
                state_next = last_step ? ST_DONE : ST_RUN;
            end
            ST_DONE: begin
                bus.busy      = 1'b1;
                bus.res_valid = 1'b1;
                // A start offered now waits for the following IDLE cycle
                state_next    = bus.res_ready ? ST_IDLE : ST_DONE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath: operand load, per-step shifting, and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_reg     <= '0;
            carry_reg    <= 1'b0;
            a_sh_reg     <= '0;
            b_sh_reg     <= '0;
            sum_sh_reg   <= '0;
            sum_out_reg  <= '0;
            cout_out_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.start_valid) begin
                        a_sh_reg  <= bus.a;
                        b_sh_reg  <= bus.b;
                        carry_reg <= bus.cin;
                        step_reg  <= '0;
                    end
                end
                ST_RUN: begin
                    a_sh_reg   <= a_sh_reg >> 2;
                    b_sh_reg   <= b_sh_reg >> 2;
                    sum_sh_reg <= sum_sh_next;
                    carry_reg  <= slice_co;
                    step_reg   <= step_reg + STEPW'(1);
                    // Output holds the previous result until this one completes
                    if (last_step) begin
                        sum_out_reg  <= sum_sh_next;
                        cout_out_reg <= slice_co;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.sum  = sum_out_reg;
    assign bus.cout = cout_out_reg;
endmodule

// File: tb/tb_adder2_seq_ctrl.sv
// Scoreboard bench for the serial adder sequencer (WIDTH=8 and WIDTH=2 instances).
module tb_adder2_seq_ctrl;
    logic clk;
    logic rst_n;

    adder2_seq_ctrl_if #(.WIDTH(8)) if8 ();
    adder2_seq_ctrl_if #(.WIDTH(2)) if2 ();

    adder2_seq_ctrl #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(if8));
    adder2_seq_ctrl #(.WIDTH(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    int checks   = 0;
    int failures = 0;

    logic [8:0] sb8[$];
    logic [2:0] sb2[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: pop and compare on every result handshake
    always @(negedge clk) begin : monitor
        logic [8:0] e8;
        logic [2:0] e2;
        if (rst_n && if8.res_valid && if8.res_ready) begin
            if (sb8.size() == 0) begin
                check("u8_unexpected_result", 32'd1, 32'd0);
            end else begin
                e8 = sb8.pop_front();
                check("u8_result", {23'd0, if8.cout, if8.sum}, {23'd0, e8});
                $display("txn u8 result cout=%0d sum=%02h expected=%03h", if8.cout, if8.sum, e8);
            end
        end
        if (rst_n && if2.res_valid && if2.res_ready) begin
            if (sb2.size() == 0) begin
                check("u2_unexpected_result", 32'd1, 32'd0);
            end else begin
                e2 = sb2.pop_front();
                check("u2_result", {29'd0, if2.cout, if2.sum}, {29'd0, e2});
                $display("txn u2 result cout=%0d sum=%0d expected=%0d", if2.cout, if2.sum, e2);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                           input bit push, input logic [8:0] exp);
        int n = 0;
        while (!if8.start_ready && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) check("u8_start_ready_timeout", 32'd1, 32'd0);
        if8.a = av;
        if8.b = bv;
        if8.cin = cv;
        if8.start_valid = 1'b1;
        if (push) sb8.push_back(exp);
        tick();
        if8.start_valid = 1'b0;
    endtask

    task automatic wait_valid8(input int exp_lat, input bit chk_busy, input string tag);
        int cyc = 0;
        while (!if8.res_valid && cyc < 40) begin
            tick();
            cyc++;
            if (chk_busy) begin
                check({tag, "_busy"}, {31'd0, if8.busy}, 32'd1);
                check({tag, "_start_ready_low"}, {31'd0, if8.start_ready}, 32'd0);
            end
        end
        check({tag, "_latency"}, cyc, exp_lat);
    endtask

    task automatic handshake8();
        if8.res_ready = 1'b1;
        tick();
        if8.res_ready = 1'b0;
    endtask

    task automatic check_idle8(input string tag, input logic [7:0] s, input logic c);
        check({tag, "_start_ready"}, {31'd0, if8.start_ready}, 32'd1);
        check({tag, "_busy"}, {31'd0, if8.busy}, 32'd0);
        check({tag, "_res_valid"}, {31'd0, if8.res_valid}, 32'd0);
        check({tag, "_sum"}, {24'd0, if8.sum}, {24'd0, s});
        check({tag, "_cout"}, {31'd0, if8.cout}, {31'd0, c});
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst_n = 1'b0;
        if8.start_valid = 0; if8.a = 0; if8.b = 0; if8.cin = 0; if8.res_ready = 0;
        if2.start_valid = 0; if2.a = 0; if2.b = 0; if2.cin = 0; if2.res_ready = 0;
        tick();
        tick();
        check_idle8("reset", 8'h00, 1'b0);
        check("u2_reset_start_ready", {31'd0, if2.start_ready}, 32'd1);
        check("u2_reset_res_valid", {31'd0, if2.res_valid}, 32'd0);
        #2 rst_n = 1'b1;
        tick();

        // 1: FF + 01, carry ripples through all four steps
        accept8(8'hFF, 8'h01, 1'b0, 1'b1, 9'h100);
        wait_valid8(4, 1'b0, "t1");
        handshake8();
        check("t1_res_valid_drop", {31'd0, if8.res_valid}, 32'd0);

        // 2: 5A + 33 + 1, busy/start_ready checked every cycle
        accept8(8'h5A, 8'h33, 1'b1, 1'b1, 9'h08E);
        check("t2_busy_accept", {31'd0, if8.busy}, 32'd1);
        wait_valid8(4, 1'b1, "t2");
        handshake8();
        check_idle8("t2_after", 8'h8E, 1'b0);

        // 3: C3 + 4E held in DONE while inputs toggle
        accept8(8'hC3, 8'h4E, 1'b0, 1'b1, 9'h111);
        wait_valid8(4, 1'b0, "t3");
        for (int i = 0; i < 10; i++) begin
            if8.start_valid = 1'($urandom_range(0, 1));
            if8.a = 8'($urandom);
            if8.b = 8'($urandom);
            if8.cin = 1'($urandom_range(0, 1));
            tick();
            check("t3_hold_valid", {31'd0, if8.res_valid}, 32'd1);
            check("t3_hold_sum", {24'd0, if8.sum}, 32'h11);
            check("t3_hold_cout", {31'd0, if8.cout}, 32'd1);
            check("t3_hold_no_accept", {31'd0, if8.start_ready}, 32'd0);
        end
        if8.start_valid = 1'b0;
        handshake8();
        check_idle8("t3_after", 8'h11, 1'b1);

        // 4: reset pulse at RUN step 2 aborts the op
        accept8(8'hAA, 8'h55, 1'b1, 1'b0, 9'h000);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check_idle8("t4_in_reset", 8'h00, 1'b0);
        #2 rst_n = 1'b1;
        tick();
        check("t4_release_start_ready", {31'd0, if8.start_ready}, 32'd1);
        check("t4_release_busy", {31'd0, if8.busy}, 32'd0);
        accept8(8'h10, 8'h20, 1'b0, 1'b1, 9'h030);
        wait_valid8(4, 1'b0, "t4");
        handshake8();

        // 5: start offered during the DONE handshake waits one cycle
        accept8(8'h7F, 8'h01, 1'b1, 1'b1, 9'h081);
        wait_valid8(4, 1'b0, "t5a");
        if8.res_ready = 1'b1;
        if8.a = 8'h12; if8.b = 8'h34; if8.cin = 1'b0;
        if8.start_valid = 1'b1;
        tick();
        if8.res_ready = 1'b0;
        check("t5_idle_start_ready", {31'd0, if8.start_ready}, 32'd1);
        check("t5_idle_busy", {31'd0, if8.busy}, 32'd0);
        sb8.push_back(9'h046);
        tick();
        if8.start_valid = 1'b0;
        check("t5_accepted_busy", {31'd0, if8.busy}, 32'd1);
        wait_valid8(4, 1'b0, "t5b");
        handshake8();

        // 6: WIDTH=2 exhaustive, consumer always ready
        if2.res_ready = 1'b1;
        for (int av = 0; av < 4; av++) begin
            for (int bv = 0; bv < 4; bv++) begin
                for (int cv = 0; cv < 2; cv++) begin
                    int n;
                    n = 0;
                    while (!if2.start_ready && n < 20) begin
                        tick();
                        n++;
                    end
                    if (n >= 20) check("u2_start_ready_timeout", 32'd1, 32'd0);
                    if2.a = 2'(av);
                    if2.b = 2'(bv);
                    if2.cin = 1'(cv);
                    if2.start_valid = 1'b1;
                    sb2.push_back(3'(av + bv + cv));
                    tick();
                    if2.start_valid = 1'b0;
                    n = 0;
                    while (!if2.res_valid && n < 20) begin
                        tick();
                        n++;
                    end
                    check("u2_latency", n, 1);
                    tick();
                end
            end
        end
        if2.res_ready = 1'b0;
        tick();

        check("sb8_drained", sb8.size(), 0);
        check("sb2_drained", sb2.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
